autosym_reconstructor: RTL and testbench

//  Inverse of the autosymmetric restriction flow. Loads a K-variable restriction f_k and a linear map

---
 rtl/autosym_pkg.sv | 28 ++
 rtl/autosym_lambda.sv | 18 +
 rtl/autosym_reconstructor.sv | 119 +++++++++++
 tb/tb_autosym_reconstructor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetric function reconstructor.
package autosym_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_N_IN  = 7;
    localparam int unsigned DEF_K_RES = 5;
    localparam int unsigned TT_W      = 2 ** DEF_K_RES;
    localparam int unsigned CNT_W     = DEF_N_IN + 1;

    // Reference lambda for the default geometry: bit i = parity of (x & mask_i).
    function automatic logic [DEF_K_RES-1:0] lambda_apply(
        input logic [DEF_N_IN-1:0]                 x,
        input logic [DEF_K_RES-1:0][DEF_N_IN-1:0]  masks
    );
        logic [DEF_K_RES-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < DEF_K_RES; i++) begin
            y[i] = ^(x & masks[i]);
        end
        return y;
    endfunction

endpackage

// File: rtl/autosym_lambda.sv
// Combinational linear map: K parity trees, each over x masked by one row.
module autosym_lambda #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned K_RES = 5
) (
    input  logic [N_IN-1:0]             x,
    input  logic [K_RES-1:0][N_IN-1:0]  masks,
    output logic [K_RES-1:0]            y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < K_RES; i++) begin
            y[i] = ^(x & masks[i]);
        end
    end

endmodule

// File: rtl/autosym_reconstructor.sv
// Re-expands f(x) = f_k(lambda(x)) into a streamed N-input truth table.
module autosym_reconstructor
    import autosym_pkg::*;
#(
    parameter  int unsigned N_IN  = 7,
    parameter  int unsigned K_RES = 5,
    localparam int unsigned MI_W  = (K_RES > 1) ? $clog2(K_RES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mask_we,
    input  logic [MI_W-1:0]      mask_idx,
    input  logic [N_IN-1:0]      mask_data,
    input  logic [(2**K_RES)-1:0] res_table,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      out_addr,
    output logic                 out_bit,
    output logic                 out_last
);

    localparam int unsigned TBL_W = 2 ** K_RES;
    localparam int unsigned C_W   = N_IN + 1;
    localparam logic [C_W-1:0] LAST_CNT = C_W'((2 ** N_IN) - 1);

    state_e                    state, state_nxt;
    logic [K_RES-1:0][N_IN-1:0] masks, masks_nxt;
    logic [TBL_W-1:0]          tbl, tbl_nxt;
    logic [C_W-1:0]            cnt, cnt_nxt;
    logic                      valid_nxt, done_nxt, fire;
    logic [K_RES-1:0]          lam;

    // Outputs are registered from the next-state values, so lambda looks at
    // the counter and masks that will be current on the following cycle.
    autosym_lambda #(
        .N_IN  (N_IN),
        .K_RES (K_RES)
    ) u_lambda (
        .x     (cnt_nxt[N_IN-1:0]),
        .masks (masks_nxt),
        .y     (lam)
    );

    always_comb begin
        masks_nxt = masks;
        tbl_nxt   = tbl;
        cnt_nxt   = cnt;
        state_nxt = state;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        fire      = out_valid & out_ready;

        if (state != RUN && mask_we && 32'(mask_idx) < K_RES) begin
            masks_nxt[mask_idx] = mask_data;
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    tbl_nxt   = res_table;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                end
            end
            RUN: begin
                valid_nxt = 1'b1;
                if (fire) begin
                    if (cnt == LAST_CNT) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            for (int unsigned i = 0; i < K_RES; i++) begin
                masks[i] <= N_IN'(1) << i;
            end
            tbl       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            masks     <= masks_nxt;
            tbl       <= tbl_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt == RUN);
            done      <= done_nxt;
            out_valid <= valid_nxt;
            if (valid_nxt) begin
                out_addr <= cnt_nxt[N_IN-1:0];
                out_bit  <= tbl_nxt[lam];
                out_last <= (cnt_nxt == LAST_CNT);
            end else begin
                out_bit  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_autosym_reconstructor.sv
// Scoreboard bench for autosym_reconstructor at N_IN=7, K_RES=5.
module tb_autosym_reconstructor;

    typedef struct packed {
        logic [6:0] addr;
        logic       b;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mask_we = 1'b0;
    logic [2:0]  mask_idx = '0;
    logic [6:0]  mask_data = '0;
    logic [31:0] res_table = '0;
    logic        start = 1'b0;
    logic        busy, done, out_valid, out_last, out_bit;
    logic        out_ready = 1'b0;
    logic [6:0]  out_addr;

    int vectors = 0;
    int fails   = 0;

    logic [6:0] tb_masks [5];
    beat_t      exp_q [$];
    beat_t      obs_q [$];

    autosym_reconstructor #(.N_IN(7), .K_RES(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .mask_we   (mask_we),
        .mask_idx  (mask_idx),
        .mask_data (mask_data),
        .res_table (res_table),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic model_identity();
        for (int i = 0; i < 5; i++) tb_masks[i] = 7'(1 << i);
    endtask

    // Expected stream computed bit by bit from the model's masks and table.
    task automatic push_expected(input logic [31:0] tbl);
        beat_t e;
        int    lam;
        bit    par;
        exp_q.delete();
        for (int x = 0; x < 128; x++) begin
            lam = 0;
            for (int i = 0; i < 5; i++) begin
                par = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    if (tb_masks[i][j] && ((x >> j) & 1) == 1) par = ~par;
                end
                if (par) lam = lam | (1 << i);
            end
            e.addr = 7'(x);
            e.b    = tbl[lam];
            e.last = (x == 127);
            exp_q.push_back(e);
        end
    endtask

    task automatic write_mask(input logic [2:0] idx, input logic [6:0] data);
        @(negedge clk);
        mask_we = 1'b1; mask_idx = idx; mask_data = data;
        if (idx < 5) tb_masks[idx] = data;
        @(negedge clk);
        mask_we = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] tbl, input bit we,
                            input logic [2:0] idx, input logic [6:0] data);
        @(negedge clk);
        res_table = tbl; start = 1'b1;
        mask_we = we; mask_idx = idx; mask_data = data;
        if (we && idx < 5) tb_masks[idx] = data;
        @(negedge clk);
        start = 1'b0; mask_we = 1'b0;
        res_table = ~tbl;
    endtask

    // Records transferred beats; optionally disturbs or aborts at a beat count.
    task automatic collect(input bit rnd_ready, input int disturb_at, input int abort_at,
                           output int stall_err, output int done_delay,
                           output bit busy_at_done, output bit timeout);
        beat_t cur, prev;
        bit    prev_stall, disturbed;
        int    since_last;
        obs_q.delete();
        stall_err = 0; done_delay = -1; busy_at_done = 1'b1; timeout = 1'b1;
        prev_stall = 1'b0; disturbed = 1'b0; since_last = -1; prev = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0; mask_we = 1'b0;
            if (abort_at >= 0 && obs_q.size() == abort_at) begin
                rst = 1'b1; out_ready = 1'b0; timeout = 1'b0;
                break;
            end
            if (disturb_at >= 0 && obs_q.size() == disturb_at && !disturbed) begin
                start = 1'b1; mask_we = 1'b1; mask_idx = 3'd0; mask_data = 7'h7F;
                disturbed = 1'b1;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = '{addr: out_addr, b: out_bit, last: out_last};
            if (prev_stall && cur !== prev) stall_err++;
            if (since_last >= 0) since_last++;
            if (done) begin
                done_delay = since_last; busy_at_done = busy; timeout = 1'b0;
                break;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(cur);
                if (out_last) since_last = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev = cur;
        end
        out_ready = 1'b0; start = 1'b0; mask_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, out_valid, out_addr, out_bit, out_last} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b addr=%h bit=%b last=%b, expected all 0",
                     busy, done, out_valid, out_addr, out_bit, out_last);
        end
        rst = 1'b0;
        model_identity();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b valid=%b, expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_identity(input string name);
        int sd, dd; bit bd, to; beat_t e, o;
        push_expected(32'h0000_0001);
        do_start(32'h0000_0001, 1'b0, 3'd0, 7'd0);
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_addr !== 7'd0 || out_bit !== 1'b1) begin
            fails++;
            $display("FAIL %s_latency: valid=%b busy=%b addr=%h bit=%b, expected 1/1/00/1",
                     name, out_valid, busy, out_addr, out_bit);
        end
        collect(1'b0, -1, -1, sd, dd, bd, to);
        vectors++;
        if (to || dd !== 1 || bd !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: timeout=%b delay=%0d busy=%b, expected 0/1/0", name, to, dd, bd);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: done=%b one cycle later, expected 0", name, done);
        end
        vectors++;
        if (obs_q.size() !== 128) begin
            fails++;
            $display("FAIL %s_count: got %0d beats, expected 128", name, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s_beat: addr/bit/last got %h/%b/%b expected %h/%b/%b",
                         name, o.addr, o.b, o.last, e.addr, e.b, e.last);
            end
        end
    endtask

    task automatic test_xor_mask();
        int sd, dd; bit bd, to; beat_t o;
        do_start(32'h5555_5555, 1'b1, 3'd0, 7'b0000011);
        collect(1'b0, -1, -1, sd, dd, bd, to);
        vectors++;
        if (to || obs_q.size() !== 128) begin
            fails++;
            $display("FAIL xor_count: timeout=%b beats=%0d, expected 0/128", to, obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            o = obs_q[i];
            vectors++;
            if (o.addr !== 7'(i) || o.b !== ~(o.addr[0] ^ o.addr[1])) begin
                fails++;
                $display("FAIL xor_beat: addr=%h bit=%b, expected addr %h bit %b",
                         o.addr, o.b, 7'(i), ~(o.addr[0] ^ o.addr[1]));
            end
        end
    endtask

    task automatic test_random_ready();
        int sd, dd; bit bd, to; beat_t e, o;
        push_expected(32'h5555_5555);
        do_start(32'h5555_5555, 1'b0, 3'd0, 7'd0);
        collect(1'b1, -1, -1, sd, dd, bd, to);
        vectors++;
        if (to || sd !== 0 || obs_q.size() !== 128) begin
            fails++;
            $display("FAIL stall_run: timeout=%b stall_changes=%0d beats=%0d, expected 0/0/128",
                     to, sd, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                fails++;
                $display("FAIL stall_beat: addr/bit/last got %h/%b/%b expected %h/%b/%b",
                         o.addr, o.b, o.last, e.addr, e.b, e.last);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int sd, dd; bit bd, to; beat_t e, o;
        push_expected(32'h5555_5555);
        do_start(32'h5555_5555, 1'b0, 3'd0, 7'd0);
        collect(1'b0, 40, -1, sd, dd, bd, to);
        vectors++;
        if (to || obs_q.size() !== 128) begin
            fails++;
            $display("FAIL busy_count: timeout=%b beats=%0d, expected 0/128", to, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                fails++;
                $display("FAIL busy_beat: addr/bit/last got %h/%b/%b expected %h/%b/%b",
                         o.addr, o.b, o.last, e.addr, e.b, e.last);
            end
        end
    endtask

    task automatic test_mid_reset();
        int sd, dd; bit bd, to; beat_t e, o;
        push_expected(32'h5555_5555);
        do_start(32'h5555_5555, 1'b0, 3'd0, 7'd0);
        collect(1'b0, -1, 60, sd, dd, bd, to);
        vectors++;
        if (to || obs_q.size() !== 60) begin
            fails++;
            $display("FAIL abort_count: timeout=%b beats=%0d, expected 0/60", to, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                fails++;
                $display("FAIL abort_beat: addr/bit/last got %h/%b/%b expected %h/%b/%b",
                         o.addr, o.b, o.last, e.addr, e.b, e.last);
            end
        end
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if ({busy, done, out_valid, out_addr, out_bit, out_last} !== 12'h000) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b done=%b valid=%b addr=%h bit=%b last=%b, expected all 0",
                     busy, done, out_valid, out_addr, out_bit, out_last);
        end
        rst = 1'b0;
        model_identity();
        test_identity("replay");
    endtask

    task automatic test_bad_idx();
        write_mask(3'd5, 7'h7F);
        write_mask(3'd7, 7'h55);
        test_identity("bad_idx");
    endtask

    initial begin
        test_reset();
        test_identity("ident");
        test_xor_mask();
        test_random_ready();
        test_busy_ignore();
        test_mid_reset();
        test_bad_idx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
